// File: rtl/io_bridge.sv
// -----------------------------------------------------------------------------
// io_bridge
//
// Memory-mapped bridge between the CPU MEM stage and the data RAM / on-chip
// peripherals. Every bus access is decoded in the same cycle. Addresses in the
// 0xFFFFF000 page go to peripheral registers. All other addresses go to DRAM.
// Load data is returned combinationally, because the core captures it at the
// MEM/WB edge.
//
// Register map (offset within the 0xFFFFF000 page):
//   0x000 DIG   r/w  32-bit seven-segment digit data, nibble n shown on digit n
//   0x020 TIMER r/w  free-running 32-bit timer (IO_BRIDGE_TIMER_EN only)
//   0x060 LED   r/w  low 24 bits drive the LEDs
//   0x070 SW    r    synchronized switches
//   0x078 BTN   r    synchronized buttons
//
// Optional feature macro: IO_BRIDGE_TIMER_EN adds the TIMER register. Without
// the macro, offset 0x020 behaves as an unmapped offset.
//
// Parameters:
//   SCAN_DIV  cycles each digit stays lit (1..2^20)
//   DRAM_AW   DRAM word-address width
//
// Ports:
//   cpu_clk, cpu_rst       clock, async active-high reset
//   Bus_addr/wen/wdata     CPU store/load request
//   Bus_rdata              combinational load data
//   dram_addr/wen/wdata    DRAM request (word address)
//   dram_rdata             DRAM combinational read data
//   sw, button             asynchronous board inputs
//   led                    LED drive, active-high
//   dig_en                 digit select, active-low, registered
//   dig_seg                segments {DP,G..A}, active-low, registered
// -----------------------------------------------------------------------------
module io_bridge #(
  parameter int SCAN_DIV = 50000,
  parameter int DRAM_AW  = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_wen,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         button,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  localparam logic [11:0] OFF_DIG   = 12'h000;
  localparam logic [11:0] OFF_TIMER = 12'h020;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;
  localparam logic [11:0] OFF_BTN   = 12'h078;

  localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 8'hC0;  4'h1: seg_decode = 8'hF9;
      4'h2: seg_decode = 8'hA4;  4'h3: seg_decode = 8'hB0;
      4'h4: seg_decode = 8'h99;  4'h5: seg_decode = 8'h92;
      4'h6: seg_decode = 8'h82;  4'h7: seg_decode = 8'hF8;
      4'h8: seg_decode = 8'h80;  4'h9: seg_decode = 8'h90;
      4'hA: seg_decode = 8'h88;  4'hB: seg_decode = 8'h83;
      4'hC: seg_decode = 8'hC6;  4'hD: seg_decode = 8'hA1;
      4'hE: seg_decode = 8'h86;  default: seg_decode = 8'h8E;
    endcase
  endfunction

  logic        io_window;
  logic [11:0] offset;
  logic        wr_io;

  logic [31:0] dig_reg;
  logic [23:0] led_reg;
  logic [23:0] sw_meta, sw_sync;
  logic [4:0]  btn_meta, btn_sync;
  logic [19:0] scan_cnt;
  logic [2:0]  dig_idx, dig_idx_next;
  logic        scan_wrap;

  assign io_window  = (Bus_addr[31:12] == 20'hFFFFF);
  assign offset     = Bus_addr[11:0];
  assign wr_io      = Bus_wen & io_window;

  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_wdata = Bus_wdata;
  assign dram_wen   = Bus_wen & ~io_window;
  assign led        = led_reg;

  assign scan_wrap    = (scan_cnt == SCAN_LAST);
  assign dig_idx_next = scan_wrap ? dig_idx + 3'd1 : dig_idx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      dig_reg  <= '0;
      led_reg  <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
      scan_cnt <= '0;
      dig_idx  <= '0;
      dig_en   <= 8'hFE;
      dig_seg  <= 8'hC0;
    end else begin
      if (wr_io && offset == OFF_DIG) dig_reg <= Bus_wdata;
      if (wr_io && offset == OFF_LED) led_reg <= Bus_wdata[23:0];

      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= button;
      btn_sync <= btn_meta;

      scan_cnt <= scan_wrap ? 20'd0 : scan_cnt + 20'd1;
      dig_idx  <= dig_idx_next;
      // Display registers follow the index being entered, so dig_en always
      // matches dig_idx. DIG is sampled pre-edge, so a new DIG value shows
      // one edge after its store.
      dig_en   <= ~(8'd1 << dig_idx_next);
      dig_seg  <= seg_decode(dig_reg[{dig_idx_next, 2'b00} +: 4]);
    end
  end

`ifdef IO_BRIDGE_TIMER_EN
  logic [31:0] timer_reg;

  // A store has priority over the increment.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst)                        timer_reg <= '0;
    else if (wr_io && offset == OFF_TIMER) timer_reg <= Bus_wdata;
    else                                timer_reg <= timer_reg + 32'd1;
  end
`endif

  // NOTE: the default assignment comes first, so every path through this
  // block assigns Bus_rdata and no latch is inferred.
  always_comb begin
    Bus_rdata = 32'h0;
    if (!io_window) begin
      Bus_rdata = dram_rdata;
    end else begin
      case (offset)
        OFF_DIG:   Bus_rdata = dig_reg;
`ifdef IO_BRIDGE_TIMER_EN
        OFF_TIMER: Bus_rdata = timer_reg;
`endif
        OFF_LED:   Bus_rdata = {8'b0, led_reg};
        OFF_SW:    Bus_rdata = {8'b0, sw_sync};
        OFF_BTN:   Bus_rdata = {27'b0, btn_sync};
        default:   Bus_rdata = 32'h0;
      endcase
    end
  end

endmodule
